memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the data memory size in bytes; it SHALL be a power of two and at least 16.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have e_icode, input, 4 bits: executed instruction code.
REQ-005 SHALL have e_cnd, input, 1 bit: condition result from execute.
REQ-006 SHALL have e_valE and e_valA, inputs, 64 bits each: ALU result and the A operand.
REQ-007 SHALL have e_dstE and e_dstM, inputs, 4 bits each: destination register IDs.
REQ-008 SHALL have e_stat, input, 2 bits: incoming status (AOK=0, HLT=1, ADR=2, INS=3).
REQ-009 SHALL have m_stall and m_bubble, inputs, 1 bit each: pipeline control for the M register.
REQ-010 SHALL have w_icode (4), w_valE (64), w_valM (64), w_dstE (4), w_dstM (4) and w_stat (2), all outputs: registered writeback-stage fields.
REQ-011 SHALL have m_valM, output, 64 bits: combinational read data for forwarding.
REQ-012 SHALL have m_stat, output, 2 bits: combinational post-access status of the M register.
REQ-013 SHALL have m_mispredict, output, 1 bit: a not-taken jump sits in M.
REQ-014 SHALL have m_halted, output, 1 bit: sticky machine-stopped flag.

Function
REQ-015 SHALL hold an M register (icode, cnd, valE, valA, dstE, dstM, stat) loaded from the e_* inputs each rising edge unless stalled or bubbled.
REQ-016 SHALL, when m_stall=1, hold the M register unchanged and load a bubble into the W register; stall takes priority over m_bubble.
REQ-017 SHALL, when m_bubble=1 and m_stall=0, load the M register with a bubble: icode=1 (nop), dstE=dstM=0xF, stat=AOK, cnd=0, data=0.
REQ-018 SHALL, at capture, replace dstE with 0xF when e_icode=2 (cmovxx) and e_cnd=0.
REQ-019 SHALL use the memory address from valE for icodes 4, 5, 8 and A, and from valA for icodes 9 and B.
REQ-020 SHALL write for icodes 4, 8 and A, writing 64-bit valA little-endian; it SHALL read for icodes 5, 9 and B.
REQ-021 SHALL flag an address as invalid when addr > MEM_BYTES-8 (no wrap); an access to an invalid address SHALL neither write nor read, and m_valM SHALL be 0.
REQ-022 SHALL compute m_stat as ADR on an invalid access when the M stat is AOK, and otherwise pass the M stat through.
REQ-023 SHALL perform writes at the rising edge that ends the M cycle; read data SHALL be combinational from the M register, giving a 1-cycle E-to-W latency.
REQ-024 SHALL suppress the memory write when the M stat is not AOK, when m_halted=1, or when m_stall=1.
REQ-025 SHALL set m_halted at the edge where m_stat is not AOK; it SHALL stay set until rst, and while it is set the W register SHALL hold its value.
REQ-026 SHALL drive m_mispredict=1 when M icode=7 and cnd=0; in that case valA carries the fall-through PC.
REQ-027 SHALL make the W register capture icode, valE, m_valM, dstE, dstM and m_stat.
REQ-028 SHALL ensure that a read in M of an address written by the W-bound instruction of the previous cycle returns the new data (write-before-read ordering across edges).

Reset
REQ-029 SHALL, on rst, load bubbles into both the M and W registers (w_icode=1, w_dstE=w_dstM=0xF, w_stat=AOK, w_valE=w_valM=0) and clear m_halted.
REQ-030 SHALL leave memory contents untouched by rst; rst SHALL take priority over stall and bubble, including in the middle of an operation.

Structure
REQ-031 SHALL take icode values, stat codes, RNONE=0xF and the bubble field values from a shared package, y86_pkg.
REQ-032 SHALL place the byte array in one sub-module, data_memory, which has a 64-bit combinational read port, a 64-bit synchronous write port and an address-valid output.

Verification
REQ-033 SHALL cover this scenario: rmmovq with valE=0x40 and valA=0x1122334455667788, then mrmovq with valE=0x40 -> w_valM=0x1122334455667788, and byte 0x40 reads 0x88.
REQ-034 SHALL cover this scenario: mrmovq with valE=MEM_BYTES-7 -> w_stat=ADR, no write, m_halted=1, and the following pushq does not write.
REQ-035 SHALL cover this scenario: cmovxx with e_cnd=0 and e_dstE=3 -> w_dstE=0xF.
REQ-036 SHALL cover this scenario: jXX with cnd=0 and valA=0x2C -> m_mispredict=1 for exactly 1 cycle.
REQ-037 SHALL cover this scenario: m_stall=1 for 2 cycles with pushq in M -> 2 bubbles in W, a single write after release, and M unchanged while stalled.
REQ-038 SHALL cover this scenario: rst asserted mid-stream with m_halted=1 -> next cycle w_icode=1, w_stat=AOK, m_halted=0, and memory retained.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register IDs and
// the bubble images loaded into the pipeline registers.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  stat;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    icode: I_NOP, cnd: 1'b0, val_e: 64'd0, val_a: 64'd0,
    dst_e: RNONE, dst_m: RNONE, stat: STAT_AOK
  };

  localparam w_reg_t W_BUBBLE = '{
    icode: I_NOP, val_e: 64'd0, val_m: 64'd0,
    dst_e: RNONE, dst_m: RNONE, stat: STAT_AOK
  };

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
  endfunction

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
  endfunction

  // ret and popq address the stack through the old %rsp carried in valA.
  function automatic logic addr_from_val_a(input logic [3:0] icode);
    return (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data memory with a 64-bit little-endian combinational read
// port, a 64-bit synchronous write port and a bounds check (no wrap-around).
module data_memory #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic [63:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic        addr_ok
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] base;

  assign addr_ok = (addr <= 64'(MEM_BYTES - 8));
  assign base    = addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en && addr_ok) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  // Out-of-range reads return zero rather than aliased bytes.
  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      for (int i = 0; i < 8; i++) begin
        rd_data[8*i +: 8] = mem[base + AW'(i)];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data memory access, status and
// halt tracking, and the W pipeline register feeding writeback.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [1:0]  e_stat,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic [3:0]  w_icode,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic [1:0]  w_stat,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic        m_mispredict,
  output logic        m_halted
);

  m_reg_t      m_reg;
  w_reg_t      w_reg;
  logic [3:0]  cap_dst_e;
  logic [63:0] mem_addr;
  logic [63:0] mem_rd_data;
  logic        mem_ok;
  logic        mem_read;
  logic        mem_write;
  logic        mem_wr_en;

  // A cmov whose condition failed must not write its destination.
  assign cap_dst_e = ((e_icode == I_RRMOVQ) && !e_cnd) ? RNONE : e_dstE;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg <= M_BUBBLE;
    end else if (m_stall) begin
      m_reg <= m_reg;
    end else if (m_bubble) begin
      m_reg <= M_BUBBLE;
    end else begin
      m_reg <= '{icode: e_icode, cnd: e_cnd, val_e: e_valE, val_a: e_valA,
                 dst_e: cap_dst_e, dst_m: e_dstM, stat: e_stat};
    end
  end

  assign mem_read  = is_mem_read(m_reg.icode);
  assign mem_write = is_mem_write(m_reg.icode);
  assign mem_addr  = addr_from_val_a(m_reg.icode) ? m_reg.val_a : m_reg.val_e;

  // Faulted or stopped instructions, and a stalled M, must not touch memory.
  assign mem_wr_en = mem_write && (m_reg.stat == STAT_AOK) && !m_halted && !m_stall;

  data_memory #(
    .MEM_BYTES(MEM_BYTES)
  ) u_mem (
    .clk     (clk),
    .addr    (mem_addr),
    .wr_en   (mem_wr_en),
    .wr_data (m_reg.val_a),
    .rd_data (mem_rd_data),
    .addr_ok (mem_ok)
  );

  assign m_valM = (mem_read && mem_ok) ? mem_rd_data : 64'd0;
  assign m_stat = ((m_reg.stat == STAT_AOK) && (mem_read || mem_write) && !mem_ok)
                  ? STAT_ADR : m_reg.stat;
  assign m_mispredict = (m_reg.icode == I_JXX) && !m_reg.cnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_halted <= 1'b0;
    end else if (m_stat != STAT_AOK) begin
      m_halted <= 1'b1;
    end
  end

  // Once halted, W freezes so the faulting instruction stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg <= W_BUBBLE;
    end else if (m_halted) begin
      w_reg <= w_reg;
    end else if (m_stall) begin
      w_reg <= W_BUBBLE;
    end else begin
      w_reg <= '{icode: m_reg.icode, val_e: m_reg.val_e, val_m: m_valM,
                 dst_e: m_reg.dst_e, dst_m: m_reg.dst_m, stat: m_stat};
    end
  end

  assign w_icode = w_reg.icode;
  assign w_valE  = w_reg.val_e;
  assign w_valM  = w_reg.val_m;
  assign w_dstE  = w_reg.dst_e;
  assign w_dstM  = w_reg.dst_m;
  assign w_stat  = w_reg.stat;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a table of single instructions, each
// followed by a nop, plus hand sequences for stall, halt and reset.
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [1:0]  e_stat;
  logic        m_stall;
  logic        m_bubble;
  logic [3:0]  w_icode;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [1:0]  w_stat;
  logic [63:0] m_valM;
  logic [1:0]  m_stat;
  logic        m_mispredict;
  logic        m_halted;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(
    .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .e_icode      (e_icode),
    .e_cnd        (e_cnd),
    .e_valE       (e_valE),
    .e_valA       (e_valA),
    .e_dstE       (e_dstE),
    .e_dstM       (e_dstM),
    .e_stat       (e_stat),
    .m_stall      (m_stall),
    .m_bubble     (m_bubble),
    .w_icode      (w_icode),
    .w_valE       (w_valE),
    .w_valM       (w_valM),
    .w_dstE       (w_dstE),
    .w_dstM       (w_dstM),
    .w_stat       (w_stat),
    .m_valM       (m_valM),
    .m_stat       (m_stat),
    .m_mispredict (m_mispredict),
    .m_halted     (m_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        bubble;
    logic [63:0] exp_val_m;
    logic [1:0]  exp_stat;
    logic        exp_misp;
    logic [3:0]  exp_w_icode;
    logic [63:0] exp_w_val_e;
    logic [3:0]  exp_w_dst_e;
    logic [3:0]  exp_w_dst_m;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] icode, input logic cnd,
                              input logic [63:0] val_e, input logic [63:0] val_a,
                              input logic [3:0] dst_e, input logic [3:0] dst_m,
                              input logic bubble, input logic [63:0] exp_val_m,
                              input logic [1:0] exp_stat, input logic exp_misp,
                              input logic [3:0] exp_w_icode, input logic [63:0] exp_w_val_e,
                              input logic [3:0] exp_w_dst_e, input logic [3:0] exp_w_dst_m);
    vec_t v;
    v.icode = icode;             v.cnd = cnd;
    v.val_e = val_e;             v.val_a = val_a;
    v.dst_e = dst_e;             v.dst_m = dst_m;
    v.bubble = bubble;           v.exp_val_m = exp_val_m;
    v.exp_stat = exp_stat;       v.exp_misp = exp_misp;
    v.exp_w_icode = exp_w_icode; v.exp_w_val_e = exp_w_val_e;
    v.exp_w_dst_e = exp_w_dst_e; v.exp_w_dst_m = exp_w_dst_m;
    return v;
  endfunction

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = dut.u_mem.mem[a + i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_e(input logic [3:0] icode, input logic cnd, input logic [63:0] val_e,
                       input logic [63:0] val_a, input logic [3:0] dst_e,
                       input logic [3:0] dst_m, input logic [1:0] stat);
    e_icode = icode; e_cnd = cnd; e_valE = val_e; e_valA = val_a;
    e_dstE = dst_e;  e_dstM = dst_m; e_stat = stat;
  endtask

  task automatic set_nop();
    set_e(4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 2'd0);
  endtask

  // One instruction through M, then a nop behind it so it lands alone in W.
  task automatic applyStimulus(input vec_t v, input int idx);
    set_e(v.icode, v.cnd, v.val_e, v.val_a, v.dst_e, v.dst_m, 2'd0);
    m_bubble = v.bubble;
    tick();
    m_bubble = 1'b0;
    checkOutput($sformatf("v%0d m_valM", idx), m_valM, v.exp_val_m);
    checkOutput($sformatf("v%0d m_stat", idx), 64'(m_stat), 64'(v.exp_stat));
    checkOutput($sformatf("v%0d m_mispredict", idx), 64'(m_mispredict), 64'(v.exp_misp));
    set_nop();
    tick();
    checkOutput($sformatf("v%0d w_icode", idx), 64'(w_icode), 64'(v.exp_w_icode));
    checkOutput($sformatf("v%0d w_valE", idx), w_valE, v.exp_w_val_e);
    checkOutput($sformatf("v%0d w_valM", idx), w_valM, v.exp_val_m);
    checkOutput($sformatf("v%0d w_dstE", idx), 64'(w_dstE), 64'(v.exp_w_dst_e));
    checkOutput($sformatf("v%0d w_dstM", idx), 64'(w_dstM), 64'(v.exp_w_dst_m));
    checkOutput($sformatf("v%0d w_stat", idx), 64'(w_stat), 64'(v.exp_stat));
    checkOutput($sformatf("v%0d mispredict cleared", idx), 64'(m_mispredict), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(4'h3, 0, 64'h55, 64'h0, 4'h2, 4'hF, 0, 64'h0, 2'd0, 0, 4'h3, 64'h55, 4'h2, 4'hF);
    vecs[1]  = mk(4'h4, 0, 64'h40, 64'h1122334455667788, 4'hF, 4'hF, 0,
                  64'h0, 2'd0, 0, 4'h4, 64'h40, 4'hF, 4'hF);
    vecs[2]  = mk(4'h4, 0, 64'h200, 64'h0, 4'hF, 4'hF, 0, 64'h0, 2'd0, 0, 4'h4, 64'h200, 4'hF, 4'hF);
    vecs[3]  = mk(4'h4, 0, 64'h300, 64'h0, 4'hF, 4'hF, 0, 64'h0, 2'd0, 0, 4'h4, 64'h300, 4'hF, 4'hF);
    vecs[4]  = mk(4'h5, 0, 64'h40, 64'h0, 4'hF, 4'h5, 0,
                  64'h1122334455667788, 2'd0, 0, 4'h5, 64'h40, 4'hF, 4'h5);
    vecs[5]  = mk(4'h2, 0, 64'h99, 64'h99, 4'h3, 4'hF, 0, 64'h0, 2'd0, 0, 4'h2, 64'h99, 4'hF, 4'hF);
    vecs[6]  = mk(4'h2, 1, 64'h99, 64'h99, 4'h3, 4'hF, 0, 64'h0, 2'd0, 0, 4'h2, 64'h99, 4'h3, 4'hF);
    vecs[7]  = mk(4'h7, 0, 64'h0, 64'h2C, 4'hF, 4'hF, 0, 64'h0, 2'd0, 1, 4'h7, 64'h0, 4'hF, 4'hF);
    vecs[8]  = mk(4'h7, 1, 64'h0, 64'h2C, 4'hF, 4'hF, 0, 64'h0, 2'd0, 0, 4'h7, 64'h0, 4'hF, 4'hF);
    vecs[9]  = mk(4'hA, 0, 64'h100, 64'hDEADBEEFCAFEF00D, 4'h4, 4'hF, 0,
                  64'h0, 2'd0, 0, 4'hA, 64'h100, 4'h4, 4'hF);
    vecs[10] = mk(4'hB, 0, 64'h108, 64'h100, 4'h4, 4'h1, 0,
                  64'hDEADBEEFCAFEF00D, 2'd0, 0, 4'hB, 64'h108, 4'h4, 4'h1);
    vecs[11] = mk(4'h8, 0, 64'h3F8, 64'h77, 4'h4, 4'hF, 0, 64'h0, 2'd0, 0, 4'h8, 64'h3F8, 4'h4, 4'hF);
    vecs[12] = mk(4'h9, 0, 64'h400, 64'h3F8, 4'h4, 4'hF, 0, 64'h77, 2'd0, 0, 4'h9, 64'h400, 4'h4, 4'hF);
    vecs[13] = mk(4'h3, 0, 64'h33, 64'h0, 4'h6, 4'hF, 1, 64'h0, 2'd0, 0, 4'h1, 64'h0, 4'hF, 4'hF);

    rst = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    set_nop();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset w_icode", 64'(w_icode), 64'h1);
    checkOutput("reset w_valE", w_valE, 64'h0);
    checkOutput("reset w_valM", w_valM, 64'h0);
    checkOutput("reset w_dstE", 64'(w_dstE), 64'hF);
    checkOutput("reset w_dstM", 64'(w_dstM), 64'hF);
    checkOutput("reset w_stat", 64'(w_stat), 64'h0);
    checkOutput("reset m_halted", 64'(m_halted), 64'h0);
    checkOutput("reset m_mispredict", 64'(m_mispredict), 64'h0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput($sformatf("v%0d m_halted", i), 64'(m_halted), 64'h0);
    end

    checkOutput("byte 0x40", 64'(dut.u_mem.mem[64]), 64'h88);
    checkOutput("byte 0x47", 64'(dut.u_mem.mem[71]), 64'h11);

    // Two stall cycles with pushq held in M; e_* carries a different op meanwhile.
    set_e(4'hA, 0, 64'h200, 64'hA5A5A5A55A5A5A5A, 4'h4, 4'hF, 2'd0);
    tick();
    m_stall = 1'b1;
    set_e(4'h3, 0, 64'h55, 64'h0, 4'h2, 4'hF, 2'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("stall%0d w_icode", c), 64'(w_icode), 64'h1);
      checkOutput($sformatf("stall%0d w_dstE", c), 64'(w_dstE), 64'hF);
      checkOutput($sformatf("stall%0d mem", c), mem_word(32'h200), 64'h0);
    end
    m_stall = 1'b0;
    set_nop();
    tick();
    checkOutput("release w_icode", 64'(w_icode), 64'hA);
    checkOutput("release w_valE", w_valE, 64'h200);
    checkOutput("release mem", mem_word(32'h200), 64'hA5A5A5A55A5A5A5A);
    tick();
    checkOutput("after release w_icode", 64'(w_icode), 64'h1);

    // Stalled mispredicted jump keeps signalling until it leaves M.
    set_e(4'h7, 0, 64'h0, 64'h2C, 4'hF, 4'hF, 2'd0);
    tick();
    checkOutput("jxx m_mispredict", 64'(m_mispredict), 64'h1);
    m_stall = 1'b1;
    set_nop();
    tick();
    checkOutput("jxx stalled m_mispredict", 64'(m_mispredict), 64'h1);
    m_stall = 1'b0;
    tick();
    checkOutput("jxx released w_icode", 64'(w_icode), 64'h7);
    checkOutput("jxx released m_mispredict", 64'(m_mispredict), 64'h0);

    // Out-of-range load halts the machine; the pushq behind it must not write.
    set_e(4'h5, 0, 64'(MEM_BYTES - 7), 64'h0, 4'hF, 4'h3, 2'd0);
    tick();
    checkOutput("adr m_stat", 64'(m_stat), 64'h2);
    checkOutput("adr m_valM", m_valM, 64'h0);
    set_e(4'hA, 0, 64'h300, 64'h1234, 4'h4, 4'hF, 2'd0);
    tick();
    checkOutput("adr w_stat", 64'(w_stat), 64'h2);
    checkOutput("adr w_icode", 64'(w_icode), 64'h5);
    checkOutput("adr w_valM", w_valM, 64'h0);
    checkOutput("adr m_halted", 64'(m_halted), 64'h1);
    set_nop();
    tick();
    checkOutput("halted push mem", mem_word(32'h300), 64'h0);
    checkOutput("halted w_icode", 64'(w_icode), 64'h5);
    checkOutput("halted w_stat", 64'(w_stat), 64'h2);
    tick();
    checkOutput("halted sticky", 64'(m_halted), 64'h1);

    // Reset wins over simultaneous stall and bubble requests.
    rst = 1'b1; m_stall = 1'b1; m_bubble = 1'b1;
    set_e(4'h3, 0, 64'h77, 64'h0, 4'h2, 4'hF, 2'd0);
    tick();
    rst = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    set_nop();
    checkOutput("rst w_icode", 64'(w_icode), 64'h1);
    checkOutput("rst w_stat", 64'(w_stat), 64'h0);
    checkOutput("rst w_dstE", 64'(w_dstE), 64'hF);
    checkOutput("rst w_valE", w_valE, 64'h0);
    checkOutput("rst m_halted", 64'(m_halted), 64'h0);
    checkOutput("rst m_stat", 64'(m_stat), 64'h0);
    tick();
    checkOutput("post rst w_icode", 64'(w_icode), 64'h1);
    checkOutput("retained 0x40", mem_word(32'h40), 64'h1122334455667788);
    checkOutput("retained 0x3F8", mem_word(32'h3F8), 64'h77);
    applyStimulus(vecs[4], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
